// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the main control unit and the mult/div sequencer.
// The control unit drives requests; the sequencer drives unit starts, HI/LO control and status.
interface muldiv_sequencer_if;
  logic        mult_req;
  logic        div_req;
  logic [31:0] b_operand;
  logic        abort;
  logic        mult_ctrl;
  logic        div_ctrl;
  logic        hi_src;
  logic        lo_src;
  logic        hilo_write;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output mult_req, div_req, b_operand, abort,
    input  mult_ctrl, div_ctrl, hi_src, lo_src,
    input  hilo_write, busy, done, div_zero
  );

  modport slave (
    input  mult_req, div_req, b_operand, abort,
    output mult_ctrl, div_ctrl, hi_src, lo_src,
    output hilo_write, busy, done, div_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multicycle sequencer for the shared multiply/divide units and HI/LO.
// Starts the selected unit, counts its iterations and commits the result.
module muldiv_sequencer #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, START, RUN, WRITE, DONE, DIVZ
  } state_t;

  state_t             state, state_nx;
  logic               op, op_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;

  // State, op flag and iteration counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      op    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      op    <= op_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic and Moore outputs, with abort suppressing commits
  always_comb begin
    state_nx       = state;
    op_nx          = op;
    cnt_nx         = cnt;
    bus.mult_ctrl  = 1'b0;
    bus.div_ctrl   = 1'b0;
    bus.hi_src     = op;
    bus.lo_src     = op;
    bus.hilo_write = 1'b0;
    bus.busy       = (state != IDLE);
    bus.done       = 1'b0;
    bus.div_zero   = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.mult_req) begin
          state_nx = START;
          op_nx    = 1'b0;
        end else if (bus.div_req) begin
          if (bus.b_operand == '0) begin
            state_nx = DIVZ;
          end else begin
            state_nx = START;
            op_nx    = 1'b1;
          end
        end
      end
      START: begin
        bus.mult_ctrl = !op;
        bus.div_ctrl  = op;
        cnt_nx        = op ? CNT_W'(DIV_CYCLES - 1)
                           : CNT_W'(MULT_CYCLES - 1);
        state_nx      = RUN;
      end
      RUN: begin
        if (cnt == '0) state_nx = WRITE;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      WRITE: begin
        bus.hilo_write = !bus.abort;
        state_nx       = DONE;
      end
      DONE: begin
        bus.done = !bus.abort;
        state_nx = IDLE;
      end
      DIVZ: begin
        bus.div_zero = !bus.abort;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // A flush wins over everything, including a request seen in IDLE
    if (bus.abort) begin
      state_nx = IDLE;
      op_nx    = op;
      cnt_nx   = '0;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (MULT_CYCLES=32, DIV_CYCLES=4).
// Output vector order: mult_ctrl div_ctrl hi_src lo_src hilo_write busy done div_zero.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(
    .MULT_CYCLES (32),
    .DIV_CYCLES  (4),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [7:0] outs();
    return {bus.mult_ctrl, bus.div_ctrl, bus.hi_src, bus.lo_src,
            bus.hilo_write, bus.busy, bus.done, bus.div_zero};
  endfunction

  // Expected outputs in cycle c of an accepted op of length n
  function automatic logic [7:0] exp_op(bit is_div, int n, int c, bit prev);
    logic src;
    src = (c >= 1) ? is_div : prev;
    return {(!is_div && c == 1), (is_div && c == 1), src, src,
            (c == n + 2), (c >= 1 && c <= n + 3), (c == n + 3), 1'b0};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    reset = 1'b0;
    bus.mult_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      got = outs();
      vectors++;
      if (got !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_%0d: got %b want %b", i, got, 8'h00);
      end
    end
    bus.mult_req = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_mult();
    logic [7:0] got, exp;
    for (int c = 0; c < 40; c++) begin
      bus.mult_req = (c == 0);
      #1;
      got = outs();
      exp = exp_op(1'b0, 32, c, 1'b0);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL mult c%0d: got %b want %b", c, got, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_div();
    logic [7:0] got, exp;
    bus.b_operand = 32'd7;
    for (int c = 0; c < 12; c++) begin
      bus.div_req = (c == 0);
      #1;
      got = outs();
      exp = exp_op(1'b1, 4, c, 1'b0);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL div c%0d: got %b want %b", c, got, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] got, exp;
    bus.b_operand = 32'd0;
    for (int c = 0; c < 6; c++) begin
      bus.div_req = (c == 0);
      #1;
      got = outs();
      exp = {2'b00, 1'b1, 1'b1, 1'b0, (c == 1), 1'b0, (c == 1)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL divz c%0d: got %b want %b", c, got, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] got, exp;
    for (int c = 0; c < 40; c++) begin
      bus.mult_req  = (c == 0);
      bus.div_req   = (c == 0 || c == 10);
      bus.b_operand = (c == 10) ? 32'd0 : 32'd5;
      #1;
      got = outs();
      exp = exp_op(1'b0, 32, c, 1'b1);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL simul c%0d: got %b want %b", c, got, exp);
      end
      next_cycle();
    end
    bus.div_req = 1'b0;
  endtask

  task automatic test_abort_write();
    logic [7:0] got, exp;
    for (int c = 0; c < 39; c++) begin
      bus.mult_req = (c == 0 || c == 35);
      bus.abort    = (c == 34 || c == 37);
      #1;
      got = outs();
      if (c <= 33)      exp = exp_op(1'b0, 32, c, 1'b0);
      else if (c == 34) exp = 8'b0000_0100;
      else if (c == 36) exp = 8'b1000_0100;
      else if (c == 37) exp = 8'b0000_0100;
      else              exp = 8'b0000_0000;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL abort c%0d: got %b want %b", c, got, exp);
      end
      next_cycle();
    end
    bus.mult_req = 1'b0;
    bus.abort    = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] got, exp;
    bus.b_operand = 32'd7;
    for (int c = 0; c < 13; c++) begin
      bus.div_req = (c == 0);
      reset       = (c != 5);
      #1;
      got = outs();
      exp = (c <= 5) ? exp_op(1'b1, 4, c, 1'b0) : 8'h00;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rst_run c%0d: got %b want %b", c, got, exp);
      end
      next_cycle();
    end
    reset = 1'b1;
  endtask

  initial begin
    bus.mult_req  = 1'b0;
    bus.div_req   = 1'b0;
    bus.b_operand = 32'd0;
    bus.abort     = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_simultaneous();
    test_abort_write();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
